// File: rtl/radar_rx_mc_if.sv
// rtl/radar_rx_mc_if.sv - strobed, channel-tagged sample stream from the radar receive buffer
interface radar_rx_mc_if #(
  parameter int WIDTH  = 16,
  parameter int CHAN_W = 1
) ();
  logic [WIDTH-1:0]  rx_i;
  logic [WIDTH-1:0]  rx_q;
  logic [CHAN_W-1:0] rx_chan;
  logic              rx_strobe;

  modport master (output rx_i, rx_q, rx_chan, rx_strobe);
  modport slave  (input  rx_i, rx_q, rx_chan, rx_strobe);
endinterface

// File: rtl/radar_rx_mc.sv
// rtl/radar_rx_mc.sv - multichannel radar receive buffer with serialised, strobed output
module radar_rx_mc #(
  parameter int WIDTH      = 16,
  parameter int NCHAN      = 2,
  parameter int ADDR_W     = 11,
  parameter int STROBE_GAP = 3,
  parameter int CHAN_W     = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   ena_i,
  input  logic                   dbg_i,
  input  logic [WIDTH-1:0]       pulse_num_i,
  input  logic [NCHAN*WIDTH-1:0] rx_in_i_i,
  input  logic [NCHAN*WIDTH-1:0] rx_in_q_i,
  input  logic                   ovf_clr_i,
  radar_rx_mc_if.master          rx_o,
  output logic                   ovf_o,
  output logic [15:0]            drop_cnt_o,
  output logic [ADDR_W:0]        level_o
);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRY_W = 2 * NCHAN * WIDTH;
  localparam int GAP_W   = (STROBE_GAP > 2) ? $clog2(STROBE_GAP) : 1;

  localparam logic [3:0] S_IDLE   = 4'b0001;
  localparam logic [3:0] S_LOAD   = 4'b0010;
  localparam logic [3:0] S_STROBE = 4'b0100;
  localparam logic [3:0] S_GAP    = 4'b1000;

  logic [WIDTH-1:0]   dbg_cnt;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wr_word;
  logic [ENTRY_W-1:0] rd_word;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               rd_en;
  logic               drop;
  logic [3:0]         state;
  logic [CHAN_W-1:0]  chan;
  logic [GAP_W-1:0]   gap_cnt;
  logic [WIDTH-1:0]   hold_i [NCHAN];
  logic [WIDTH-1:0]   hold_q [NCHAN];

  // Full is judged on the occupancy before any same-cycle read, so a read never rescues a write.
  assign full  = (level_o == (ADDR_W+1)'(DEPTH));
  assign empty = (level_o == '0);
  assign drop  = ena_i && full;
  assign wr_en = ena_i && !full;
  assign rd_en = (state == S_IDLE) && !empty;

  // Pack one sample set: channel c holds I in the low half and Q in the high half of its slot.
  always_comb begin
    wr_word = '0;
    for (int c = 0; c < NCHAN; c++) begin
      wr_word[2*c*WIDTH +: WIDTH]     = dbg_i ? dbg_cnt     : rx_in_i_i[c*WIDTH +: WIDTH];
      wr_word[(2*c+1)*WIDTH +: WIDTH] = dbg_i ? pulse_num_i : rx_in_q_i[c*WIDTH +: WIDTH];
    end
  end

  // Debug ramp restarts whenever capture is paused.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !ena_i) dbg_cnt <= '0;
    else                    dbg_cnt <= dbg_cnt + 1'b1;
  end

  // Sample-set storage with a registered read port; contents are invalidated via the pointers.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_en) mem[wr_ptr] <= wr_word;
    if (rst_n_i && rd_en) rd_word <= mem[rd_ptr];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_o <= level_o + (ADDR_W+1)'(1);
        2'b01:   level_o <= level_o - (ADDR_W+1)'(1);
        default: level_o <= level_o;
      endcase
    end
  end

  // Sticky overflow and saturating drop count; a same-cycle drop wins over a clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      ovf_o      <= 1'b1;
      drop_cnt_o <= ovf_clr_i ? 16'd1 : ((drop_cnt_o == 16'hFFFF) ? drop_cnt_o : drop_cnt_o + 16'd1);
    end else if (ovf_clr_i) begin
      ovf_o      <= 1'b0;
      drop_cnt_o <= '0;
    end
  end

  // Drain FSM: fetch an entry, then emit its channels one strobe at a time with a fixed cadence.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state             <= S_IDLE;
      chan              <= '0;
      gap_cnt           <= '0;
      rx_o.rx_i         <= '0;
      rx_o.rx_q         <= '0;
      rx_o.rx_chan      <= '0;
      rx_o.rx_strobe    <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        hold_i[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      rx_o.rx_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) state <= S_LOAD;
        end
        S_LOAD: begin
          for (int c = 0; c < NCHAN; c++) begin
            hold_i[c] <= rd_word[2*c*WIDTH +: WIDTH];
            hold_q[c] <= rd_word[(2*c+1)*WIDTH +: WIDTH];
          end
          chan  <= '0;
          state <= S_STROBE;
        end
        S_STROBE: begin
          rx_o.rx_i      <= hold_i[chan];
          rx_o.rx_q      <= hold_q[chan];
          rx_o.rx_chan   <= chan;
          rx_o.rx_strobe <= 1'b1;
          if (STROBE_GAP == 1) begin
            if (chan == CHAN_W'(NCHAN-1)) state <= S_IDLE;
            else begin
              chan  <= chan + 1'b1;
              state <= S_STROBE;
            end
          end else begin
            gap_cnt <= GAP_W'(STROBE_GAP-2);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            if (chan == CHAN_W'(NCHAN-1)) state <= S_IDLE;
            else begin
              chan  <= chan + 1'b1;
              state <= S_STROBE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_radar_rx_mc.sv
// tb/tb_radar_rx_mc.sv - randomized self-checking bench for radar_rx_mc against an event-time model
module tb_radar_rx_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, ena, dbg, ovf_clr;
  logic [15:0] pulse;
  logic [31:0] in_a_i, in_a_q;
  logic [63:0] in_b_i, in_b_q;
  logic        ovf_a, ovf_b;
  logic [15:0] drop_a, drop_b;
  logic [2:0]  lvl_a;
  logic [3:0]  lvl_b;

  radar_rx_mc_if #(.WIDTH(16), .CHAN_W(1)) if_a ();
  radar_rx_mc_if #(.WIDTH(16), .CHAN_W(2)) if_b ();

  radar_rx_mc #(.WIDTH(16), .NCHAN(2), .ADDR_W(2), .STROBE_GAP(3), .CHAN_W(1)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .dbg_i(dbg), .pulse_num_i(pulse),
    .rx_in_i_i(in_a_i), .rx_in_q_i(in_a_q), .ovf_clr_i(ovf_clr), .rx_o(if_a),
    .ovf_o(ovf_a), .drop_cnt_o(drop_a), .level_o(lvl_a));

  radar_rx_mc #(.WIDTH(16), .NCHAN(4), .ADDR_W(3), .STROBE_GAP(1), .CHAN_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .dbg_i(dbg), .pulse_num_i(pulse),
    .rx_in_i_i(in_b_i), .rx_in_q_i(in_b_q), .ovf_clr_i(ovf_clr), .rx_o(if_b),
    .ovf_o(ovf_b), .drop_cnt_o(drop_b), .level_o(lvl_b));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nch(input int d); return (d == 0) ? 2 : 4; endfunction
  function automatic int gap(input int d); return (d == 0) ? 3 : 1; endfunction
  function automatic int dep(input int d); return (d == 0) ? 4 : 8; endfunction

  // Model: a FIFO of sample sets plus, for the entry being emitted, the edge it was popped.
  // Channel k of that entry strobes at pop+2+k*gap; the next pop may happen at pop+2+nchan*gap.
  logic [15:0] m_fi [2][8][4];
  logic [15:0] m_fq [2][8][4];
  logic [15:0] m_ci [2][4];
  logic [15:0] m_cq [2][4];
  int          m_head [2], m_cnt [2], m_ready [2], m_pop [2];
  bit          m_busy [2];
  logic [15:0] m_dcnt;
  bit          e_stb [2], e_ovf [2];
  logic [15:0] e_i [2], e_q [2];
  int          e_chan [2], e_drop [2];
  int          edge_n = 0;

  int          stb_a, stb_b, peak_a;
  logic [15:0] seq_i [8], seq_q [8];

  task automatic model_edge();
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_head[d] = 0; m_cnt[d] = 0; m_busy[d] = 0; m_ready[d] = edge_n + 1;
        e_stb[d] = 0; e_i[d] = 0; e_q[d] = 0; e_chan[d] = 0; e_ovf[d] = 0; e_drop[d] = 0;
      end
      m_dcnt = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        int          nc, g, k, slot;
        bit          full;
        logic [63:0] vi, vq;
        nc = nch(d); g = gap(d);
        vi = (d == 0) ? {32'h0, in_a_i} : in_b_i;
        vq = (d == 0) ? {32'h0, in_a_q} : in_b_q;
        e_stb[d] = 0;
        k = edge_n - m_pop[d] - 2;
        if (m_busy[d] && k >= 0 && (k % g) == 0 && (k / g) < nc) begin
          e_stb[d]  = 1;
          e_chan[d] = k / g;
          e_i[d]    = m_ci[d][k / g];
          e_q[d]    = m_cq[d][k / g];
        end
        full = (m_cnt[d] == dep(d));
        if (edge_n >= m_ready[d] && m_cnt[d] > 0) begin
          for (int c = 0; c < 4; c++) begin
            m_ci[d][c] = m_fi[d][m_head[d]][c];
            m_cq[d][c] = m_fq[d][m_head[d]][c];
          end
          m_head[d]  = (m_head[d] + 1) % dep(d);
          m_cnt[d]   = m_cnt[d] - 1;
          m_busy[d]  = 1;
          m_pop[d]   = edge_n;
          m_ready[d] = edge_n + 2 + nc * g;
        end
        if (ena && full) begin
          e_ovf[d]  = 1;
          e_drop[d] = ovf_clr ? 1 : ((e_drop[d] == 65535) ? 65535 : e_drop[d] + 1);
        end else begin
          if (ovf_clr) begin
            e_ovf[d] = 0; e_drop[d] = 0;
          end
          if (ena) begin
            slot = (m_head[d] + m_cnt[d]) % dep(d);
            for (int c = 0; c < nc; c++) begin
              m_fi[d][slot][c] = dbg ? m_dcnt : vi[c*16 +: 16];
              m_fq[d][slot][c] = dbg ? pulse  : vq[c*16 +: 16];
            end
            m_cnt[d] = m_cnt[d] + 1;
          end
        end
      end
      m_dcnt = ena ? m_dcnt + 16'd1 : 16'd0;
    end
  endtask

  task automatic compare();
    check("a_stb",  32'(if_a.rx_strobe), 32'(e_stb[0]));
    check("a_i",    32'(if_a.rx_i),      32'(e_i[0]));
    check("a_q",    32'(if_a.rx_q),      32'(e_q[0]));
    check("a_chan", 32'(if_a.rx_chan),   32'(e_chan[0]));
    check("a_lvl",  32'(lvl_a),          32'(m_cnt[0]));
    check("a_ovf",  32'(ovf_a),          32'(e_ovf[0]));
    check("a_drop", 32'(drop_a),         32'(e_drop[0]));
    check("b_stb",  32'(if_b.rx_strobe), 32'(e_stb[1]));
    check("b_i",    32'(if_b.rx_i),      32'(e_i[1]));
    check("b_q",    32'(if_b.rx_q),      32'(e_q[1]));
    check("b_chan", 32'(if_b.rx_chan),   32'(e_chan[1]));
    check("b_lvl",  32'(lvl_b),          32'(m_cnt[1]));
    check("b_ovf",  32'(ovf_b),          32'(e_ovf[1]));
    check("b_drop", 32'(drop_b),         32'(e_drop[1]));
    if (if_a.rx_strobe === 1'b1) begin
      if (stb_a < 8) begin
        seq_i[stb_a] = if_a.rx_i;
        seq_q[stb_a] = if_a.rx_q;
      end
      stb_a++;
    end
    if (if_b.rx_strobe === 1'b1) stb_b++;
    if (int'(lvl_a) > peak_a) peak_a = int'(lvl_a);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic drain_idle();
    int g;
    ena = 0; ovf_clr = 0; dbg = 0;
    g = 0;
    while (g < 300 && !(m_cnt[0] == 0 && m_cnt[1] == 0 &&
                        edge_n >= m_ready[0] && edge_n >= m_ready[1])) begin
      step();
      g++;
    end
    check("drain_bound", 32'(g < 300), 32'd1);
  endtask

  task automatic fill_a();
    int g;
    ena = 1;
    g = 0;
    while (g < 20 && m_cnt[0] < 4) begin
      step();
      g++;
    end
  endtask

  initial begin
    rst_n = 0; ena = 0; dbg = 0; ovf_clr = 0; pulse = 0;
    in_a_i = 0; in_a_q = 0; in_b_i = 0; in_b_q = 0;
    stb_a = 0; stb_b = 0; peak_a = 0;
    @(negedge clk);
    step(); step();
    rst_n = 1;

    // Single entry: two strobes from the 2-channel buffer, four back-to-back from the 4-channel one.
    in_a_i = {16'h3333, 16'h1111}; in_a_q = {16'h4444, 16'h2222};
    in_b_i = {$urandom, $urandom}; in_b_q = {$urandom, $urandom};
    stb_a = 0; stb_b = 0;
    ena = 1; step(); ena = 0;
    repeat (12) step();
    check("basic_cnt_a", 32'(stb_a), 32'd2);
    check("basic_cnt_b", 32'(stb_b), 32'd4);
    check("basic_ch1_i", 32'(seq_i[1]), 32'h3333);
    drain_idle();

    // Debug ramp from reset.
    rst_n = 0; step(); rst_n = 1;
    stb_a = 0;
    dbg = 1; pulse = 16'h0005; ena = 1;
    repeat (4) step();
    ena = 0; dbg = 0;
    repeat (40) step();
    check("dbg_cnt_a", 32'(stb_a), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("dbg_i%0d", k), 32'(seq_i[k]), 32'(k / 2));
      check($sformatf("dbg_q%0d", k), 32'(seq_q[k]), 32'h5);
    end
    drain_idle();

    // Overflow on the 4-deep buffer draining one entry every 8 cycles.
    peak_a = 0;
    ena = 1; repeat (10) step(); ena = 0;
    check("ovf_peak", 32'(peak_a), 32'd4);
    check("ovf_flag", 32'(ovf_a), 32'd1);
    check("ovf_drop", 32'(drop_a), 32'd5);
    ovf_clr = 1; step(); ovf_clr = 0;
    check("clr_flag", 32'(ovf_a), 32'd0);
    check("clr_drop", 32'(drop_a), 32'd0);

    // Drop coinciding with clear while full.
    fill_a();
    step();
    fill_a();
    ovf_clr = 1; step(); ovf_clr = 0;
    check("clrdrop_flag", 32'(ovf_a), 32'd1);
    check("clrdrop_drop", 32'(drop_a), 32'd1);
    drain_idle();

    // Reset between the two strobes of one entry.
    stb_a = 0;
    in_a_i = $urandom; in_a_q = $urandom;
    ena = 1; step(); ena = 0;
    repeat (3) step();
    check("mid_first", 32'(stb_a), 32'd1);
    rst_n = 0; step(); rst_n = 1;
    check("mid_lvl", 32'(lvl_a), 32'd0);
    check("mid_i", 32'(if_a.rx_i), 32'd0);
    repeat (10) step();
    check("mid_noch1", 32'(stb_a), 32'd1);
    ena = 1; step(); ena = 0;
    repeat (12) step();
    check("mid_resume", 32'(stb_a), 32'd3);

    // Random traffic.
    repeat (700) begin
      ena     = ($urandom_range(0, 9) < 4);
      dbg     = ($urandom_range(0, 7) == 0);
      pulse   = 16'($urandom);
      in_a_i  = $urandom; in_a_q = $urandom;
      in_b_i  = {$urandom, $urandom}; in_b_q = {$urandom, $urandom};
      ovf_clr = ($urandom_range(0, 29) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1;
    drain_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
